// File: rtl/rr_handshake_arbiter4.sv
// rtl/rr_handshake_arbiter4.sv - four-input round-robin arbiter with 4-phase handshakes on every port
module rr_handshake_arbiter4 #(
    parameter int N           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_a_req_i,
    input  logic         in_b_req_i,
    input  logic         in_c_req_i,
    input  logic         in_d_req_i,
    input  logic [N-1:0] in_a_data_i,
    input  logic [N-1:0] in_b_data_i,
    input  logic [N-1:0] in_c_data_i,
    input  logic [N-1:0] in_d_data_i,
    output logic         in_a_ack_o,
    output logic         in_b_ack_o,
    output logic         in_c_ack_o,
    output logic         in_d_ack_o,
    output logic         out_req_o,
    output logic [N-1:0] out_data_o,
    input  logic         out_ack_i,
    output logic [1:0]   grant_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {IDLE, OUT_REQ, OUT_RTZ, IN_ACK} state_t;

    state_t         state_q;
    logic [3:0]     ack_q;
    logic           out_req_q;
    logic [N-1:0]   out_data_q;
    logic [1:0]     grant_q;

    logic [4:0]     raw_in;
    logic [4:0]     sync_s;
    logic [3:0]     req_s;
    logic           out_ack_s;
    logic [N-1:0]   in_data [4];

    logic           pick_valid_d;
    logic [1:0]     pick_idx_d;
    logic [1:0]     cand;

    assign raw_in = {out_ack_i, in_d_req_i, in_c_req_i, in_b_req_i, in_a_req_i};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_s = raw_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][4:0] sync_q;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= raw_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign sync_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign req_s     = sync_s[3:0];
    assign out_ack_s = sync_s[4];

    assign in_data[0] = in_a_data_i;
    assign in_data[1] = in_b_data_i;
    assign in_data[2] = in_c_data_i;
    assign in_data[3] = in_d_data_i;

    // grant_q doubles as the round-robin pointer: search starts just after the last winner
    always_comb begin
        pick_valid_d = 1'b0;
        pick_idx_d   = grant_q;
        cand         = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = grant_q + 2'(i);
            if (!pick_valid_d && req_s[cand]) begin
                pick_valid_d = 1'b1;
                pick_idx_d   = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
            grant_q    <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid_d) begin
                        out_data_q <= in_data[pick_idx_d];
                        grant_q    <= pick_idx_d;
                        out_req_q  <= 1'b1;
                        state_q    <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (out_ack_s) begin
                        out_req_q <= 1'b0;
                        state_q   <= OUT_RTZ;
                    end
                end
                OUT_RTZ: begin
                    if (!out_ack_s) begin
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    if (!req_s[grant_q]) begin
                        ack_q[grant_q] <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_a_ack_o = ack_q[0];
    assign in_b_ack_o = ack_q[1];
    assign in_c_ack_o = ack_q[2];
    assign in_d_ack_o = ack_q[3];
    assign out_req_o  = out_req_q;
    assign out_data_o = out_data_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_rr_handshake_arbiter4.sv
// tb/tb_rr_handshake_arbiter4.sv - directed scoreboard bench for rr_handshake_arbiter4 at S=0 and S=2
module tb_rr_handshake_arbiter4;

    localparam int N = 32;

    typedef struct {
        logic [1:0]   g;
        logic [N-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [3:0]     req0, req2;
    logic [N-1:0]   data0 [4];
    logic [N-1:0]   data2 [4];
    logic           out_ack0, out_ack2;
    wire  [3:0]     ack0, ack2;
    wire            out_req0, out_req2, busy0, busy2;
    wire  [N-1:0]   out_data0, out_data2;
    wire  [1:0]     grant0, grant2;

    exp_t sb[$];
    int   n_err = 0;
    int   n_chk = 0;

    rr_handshake_arbiter4 #(.N(N), .SYNC_STAGES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_a_req_i(req0[0]), .in_b_req_i(req0[1]), .in_c_req_i(req0[2]), .in_d_req_i(req0[3]),
        .in_a_data_i(data0[0]), .in_b_data_i(data0[1]), .in_c_data_i(data0[2]), .in_d_data_i(data0[3]),
        .in_a_ack_o(ack0[0]), .in_b_ack_o(ack0[1]), .in_c_ack_o(ack0[2]), .in_d_ack_o(ack0[3]),
        .out_req_o(out_req0), .out_data_o(out_data0), .out_ack_i(out_ack0),
        .grant_o(grant0), .busy_o(busy0)
    );

    rr_handshake_arbiter4 #(.N(N), .SYNC_STAGES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_a_req_i(req2[0]), .in_b_req_i(req2[1]), .in_c_req_i(req2[2]), .in_d_req_i(req2[3]),
        .in_a_data_i(data2[0]), .in_b_data_i(data2[1]), .in_c_data_i(data2[2]), .in_d_data_i(data2[3]),
        .in_a_ack_o(ack2[0]), .in_b_ack_o(ack2[1]), .in_c_ack_o(ack2[2]), .in_d_ack_o(ack2[3]),
        .out_req_o(out_req2), .out_data_o(out_data2), .out_ack_i(out_ack2),
        .grant_o(grant2), .busy_o(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // which: 0 = out_req, 1..4 = ack of input which-1, 5 = any ack
    function automatic logic sig(input int dut, input int which);
        logic [4:0] v;
        v = (dut == 0) ? {ack0, out_req0} : {ack2, out_req2};
        if (which == 5) return |v[4:1];
        return v[which];
    endfunction

    task automatic wait_for(input int dut, input int which, input logic lvl,
                            input string tag, output int c);
        c = 0;
        while (sig(dut, which) !== lvl && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_timeout"}, 64'(c < 100), 64'(1));
    endtask

    task automatic serve0(input int d, input bit reraise);
        int   c;
        exp_t e;
        wait_for(0, 0, 1'b1, "out_req_rise", c);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("grant", 64'(grant0), 64'(e.g));
        chk("out_data", 64'(out_data0), 64'(e.d));
        chk("busy_high", 64'(busy0), 64'(1));
        repeat (d) begin
            @(negedge clk);
            chk("out_data_hold", 64'(out_data0), 64'(e.d));
        end
        out_ack0 = 1'b1;
        wait_for(0, 0, 1'b0, "out_req_fall", c);
        chk("out_req_fall_lat", 64'(c), 64'(1));
        repeat (d) begin
            @(negedge clk);
            chk("ack_early", 64'(ack0), 64'(0));
        end
        out_ack0 = 1'b0;
        wait_for(0, int'(e.g) + 1, 1'b1, "in_ack_rise", c);
        chk("in_ack_rise_lat", 64'(c), 64'(1));
        chk("ack_onehot", 64'(ack0), 64'(4'b0001 << e.g));
        chk("data_at_ack", 64'(out_data0), 64'(e.d));
        req0[e.g] = 1'b0;
        wait_for(0, 5, 1'b0, "in_ack_fall", c);
        chk("in_ack_fall_lat", 64'(c), 64'(1));
        if (reraise) req0[e.g] = 1'b1;
    endtask

    initial begin
        int   c;
        int   t;
        exp_t e;
        rst_n    = 1'b0;
        req0     = '0;
        req2     = '0;
        out_ack0 = 1'b0;
        out_ack2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data0[i] = '0;
            data2[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_ack0", 64'(ack0), 64'(0));
        chk("rst_out_req0", 64'(out_req0), 64'(0));
        chk("rst_out_data0", 64'(out_data0), 64'(0));
        chk("rst_grant0", 64'(grant0), 64'(3));
        chk("rst_busy0", 64'(busy0), 64'(0));
        chk("rst_grant2", 64'(grant2), 64'(3));
        chk("rst_busy2", 64'(busy2), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // single request on B
        data0[1] = 32'hDEADBEEF;
        req0[1]  = 1'b1;
        sb.push_back('{g: 2'd1, d: 32'hDEADBEEF});
        @(negedge clk);
        chk("single_out_req_lat", 64'(out_req0), 64'(1));
        serve0(1, 1'b0);

        // last winner B: C then A, then D alone
        data0[0] = 32'h0000_00AA;
        data0[2] = 32'h0000_00CC;
        req0[0]  = 1'b1;
        req0[2]  = 1'b1;
        sb.push_back('{g: 2'd2, d: 32'h0000_00CC});
        sb.push_back('{g: 2'd0, d: 32'h0000_00AA});
        serve0(1, 1'b0);
        serve0(1, 1'b0);
        data0[3] = 32'h0000_00DD;
        req0[3]  = 1'b1;
        sb.push_back('{g: 2'd3, d: 32'h0000_00DD});
        serve0(0, 1'b0);

        // all four continuously requesting
        for (int i = 0; i < 4; i++) data0[i] = 32'hA0 + 32'(i);
        for (int w = 0; w < 8; w++) sb.push_back('{g: 2'(w), d: 32'hA0 + 32'(w % 4)});
        req0 = 4'hF;
        for (int w = 0; w < 8; w++) serve0(0, w < 4);
        chk("all_four_drained", 64'(sb.size()), 64'(0));

        // data hold while out_ack is delayed
        data0[0] = 32'h1;
        req0[0]  = 1'b1;
        sb.push_back('{g: 2'd0, d: 32'h1});
        wait_for(0, 0, 1'b1, "hold_pick", c);
        data0[0] = 32'h2;
        serve0(10, 1'b0);

        // reset in the middle of a transfer
        data0[2] = 32'h33;
        req0[2]  = 1'b1;
        wait_for(0, 0, 1'b1, "abort_pick", c);
        chk("abort_grant_pre", 64'(grant0), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("abort_ack", 64'(ack0), 64'(0));
        chk("abort_out_req", 64'(out_req0), 64'(0));
        chk("abort_out_data", 64'(out_data0), 64'(0));
        chk("abort_grant", 64'(grant0), 64'(3));
        chk("abort_busy", 64'(busy0), 64'(0));
        data0[0] = 32'h11;
        req0[0]  = 1'b1;
        sb.delete();
        sb.push_back('{g: 2'd0, d: 32'h11});
        sb.push_back('{g: 2'd2, d: 32'h33});
        @(negedge clk);
        rst_n = 1'b1;
        serve0(0, 1'b0);
        serve0(0, 1'b0);

        // two-stage synchronizer latency on D
        data2[3] = 32'hD00D_F00D;
        req2[3]  = 1'b1;
        sb.push_back('{g: 2'd3, d: 32'hD00D_F00D});
        t = 0;
        wait_for(2, 0, 1'b1, "s2_out_req_rise", c);
        chk("s2_req_lat", 64'(c), 64'(3));
        t += c;
        e = sb.pop_front();
        chk("s2_grant", 64'(grant2), 64'(e.g));
        chk("s2_out_data", 64'(out_data2), 64'(e.d));
        chk("s2_busy_high", 64'(busy2), 64'(1));
        out_ack2 = 1'b1;
        wait_for(2, 0, 1'b0, "s2_out_req_fall", c);
        chk("s2_out_req_fall_lat", 64'(c), 64'(3));
        t += c;
        out_ack2 = 1'b0;
        wait_for(2, 4, 1'b1, "s2_in_ack_rise", c);
        chk("s2_in_ack_rise_lat", 64'(c), 64'(3));
        t += c;
        req2[3] = 1'b0;
        wait_for(2, 5, 1'b0, "s2_in_ack_fall", c);
        chk("s2_in_ack_fall_lat", 64'(c), 64'(3));
        t += c;
        chk("s2_busy_low", 64'(busy2), 64'(0));
        chk("s2_total_edges", 64'(t), 64'(12));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
